// File: rtl/mem_responder_pkg.sv
// Bus types shared with the core plus the responder's state encoding and helpers.
package mem_responder_pkg;

  localparam logic [63:0] MEM_BASE = 64'h8000_0000;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Number of bytes covered by a dbus access of the given size.
  function automatic logic [3:0] size_bytes(input msize_t size);
    logic [3:0] n;
    case (size)
      MSIZE1:  n = 4'd1;
      MSIZE2:  n = 4'd2;
      MSIZE4:  n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port 64-bit RAM: byte-strobed synchronous write, combinational read.
module mem_ram #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [7:0]            strb_i,
  input  logic [63:0]           wdata_i,
  output logic [63:0]           rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned BYTES = 8;

  logic [63:0] mem_q [DEPTH];

  // Merge strobed bytes into the addressed word; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (strb_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// On-chip memory answering the core's ibus/dbus; dbus wins arbitration in IDLE.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE       = MEM_BASE,
  parameter int unsigned LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        own_d_q, own_d_d;
  logic [63:0] addr_q, addr_d;
  msize_t      size_q, size_d;
  logic [7:0]  strb_q, strb_d;
  logic [63:0] wdata_q, wdata_d;
  ibus_resp_t  iresp_q, iresp_d;
  dbus_resp_t  dresp_q, dresp_d;
  logic        err_q, err_d;

  logic [63:0]           off_c;
  logic                  in_range_c;
  logic                  mis_c;
  logic                  is_write_c;
  logic                  owner_valid_c;
  logic                  we_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic [63:0]           ram_rdata;

  // State, latched request and registered responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_d_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= MSIZE1;
      strb_q  <= '0;
      wdata_q <= '0;
      iresp_q <= '0;
      dresp_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_d_q <= own_d_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      iresp_q <= iresp_d;
      dresp_q <= dresp_d;
      err_q   <= err_d;
    end
  end

  assign owner_valid_c = own_d_q ? dreq.valid : ireq.valid;

  // Next state and request latch: accept in IDLE, count down or flush in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d_d = own_d_q;
    addr_d  = addr_q;
    size_d  = size_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          own_d_d = 1'b1;
          addr_d  = dreq.addr;
          size_d  = dreq.size;
          strb_d  = dreq.strobe;
          wdata_d = dreq.data;
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? RESP : WAIT;
        end else if (ireq.valid) begin
          own_d_d = 1'b0;
          addr_d  = ireq.addr;
          size_d  = MSIZE4;
          strb_d  = '0;
          wdata_d = '0;
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!owner_valid_c) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decode the (next) latched address; in RESP this equals the held request.
  always_comb begin
    off_c      = addr_d - BASE;
    in_range_c = (addr_d >= BASE) && (off_c[63:DEPTH_LOG2+3] == '0);
    idx_c      = off_c[DEPTH_LOG2+2:3];
    mis_c      = own_d_d && (({1'b0, off_c[2:0]} + size_bytes(size_d)) > 4'd8);
    is_write_c = own_d_d && (strb_d != 8'h00);
    we_c       = (state_q == RESP) && is_write_c && in_range_c && !mis_c;
  end

  // Response payload, captured on entry to RESP so outputs stay registered.
  always_comb begin
    iresp_d = '0;
    dresp_d = '0;
    err_d   = 1'b0;
    if (state_d == RESP) begin
      err_d = !in_range_c || mis_c;
      if (own_d_d) begin
        dresp_d.addr_ok = 1'b1;
        dresp_d.data_ok = 1'b1;
        dresp_d.data    = in_range_c ? ram_rdata : 64'h0;
      end else begin
        iresp_d.addr_ok = 1'b1;
        iresp_d.data_ok = 1'b1;
        if (in_range_c) begin
          iresp_d.data = off_c[2] ? ram_rdata[63:32] : ram_rdata[31:0];
        end
      end
    end
  end

  mem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_c),
    .addr_i  (idx_c),
    .strb_i  (strb_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign iresp = iresp_q;
  assign dresp = dresp_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table + scoreboard, plus corner sequences.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int unsigned LAT_A   = 2;
  localparam logic [63:0] W1_ADDR = 64'h8000_0008;
  localparam logic [63:0] W1_FIN  = 64'h9988_7766_AABB_EEDD;
  localparam int          NVEC    = 20;

  logic       clk;
  logic       rst;
  ibus_req_t  ireq,  ireq0;
  ibus_resp_t iresp, iresp0;
  dbus_req_t  dreq,  dreq0;
  dbus_resp_t dresp, dresp0;
  logic       err,   err0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        is_d;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic        chk_data;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic        chk_data;
    logic [63:0] data;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];

  mem_responder #(.DEPTH_LOG2(12), .BASE(64'h8000_0000), .LATENCY(LAT_A)) dut (
    .clk(clk), .reset(rst), .ireq(ireq), .iresp(iresp),
    .dreq(dreq), .dresp(dresp), .err(err)
  );

  mem_responder #(.DEPTH_LOG2(12), .BASE(64'h8000_0000), .LATENCY(0)) dut0 (
    .clk(clk), .reset(rst), .ireq(ireq0), .iresp(iresp0),
    .dreq(dreq0), .dresp(dresp0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare against the response visible now.
  task automatic pop_check(input string nm, input int cyc);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, " unexpected response"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({nm, " latency"}, 64'(cyc), 64'(e.lat));
    if (e.is_d) begin
      chk({nm, " d_ok"}, {62'b0, dresp.addr_ok, dresp.data_ok}, 64'h3);
      chk({nm, " i_ok"}, {62'b0, iresp.addr_ok, iresp.data_ok}, 64'h0);
      if (e.chk_data) chk({nm, " d_data"}, dresp.data, e.data);
    end else begin
      chk({nm, " i_ok"}, {62'b0, iresp.addr_ok, iresp.data_ok}, 64'h3);
      chk({nm, " d_ok"}, {62'b0, dresp.addr_ok, dresp.data_ok}, 64'h0);
      if (e.chk_data) chk({nm, " i_data"}, {32'b0, iresp.data}, e.data);
    end
    chk({nm, " err"}, 64'(err), 64'(e.err));
  endtask

  // Drive one request on the LATENCY=2 instance and hold valid until data_ok.
  task automatic run_txn(input string nm, input vec_t v);
    bit done;
    exp_t e;
    done = 1'b0;
    e = '{v.is_d, v.chk_data, v.exp_data, v.exp_err, int'(LAT_A) + 1};
    sb.push_back(e);
    if (v.is_d) begin
      dreq.valid  = 1'b1;
      dreq.addr   = v.addr;
      dreq.size   = v.size;
      dreq.strobe = v.strb;
      dreq.data   = v.wdata;
    end else begin
      ireq.valid = 1'b1;
      ireq.addr  = v.addr;
    end
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (dresp.data_ok || iresp.data_ok) begin
        pop_check(nm, c);
        done = 1'b1;
      end
    end
    dreq.valid = 1'b0;
    ireq.valid = 1'b0;
    if (!done) begin
      chk({nm, " timeout"}, 64'd0, 64'd1);
      sb.delete();
    end
    @(negedge clk);
    chk({nm, " idle after"}, {61'b0, err, dresp.data_ok, iresp.data_ok}, 64'h0);
  endtask

  initial begin
    bit   dd, id, seen;
    vec_t rb;

    rst   = 1'b0;
    ireq  = '0;
    dreq  = '0;
    ireq0 = '0;
    dreq0 = '0;

    //            is_d  addr                    size    strb   wdata                   chk   exp_data                err
    vecs[0]  = '{1'b1, 64'h8000_0008, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0,                  1'b0};
    vecs[1]  = '{1'b1, 64'h8000_0008, MSIZE8, 8'h00, 64'h0,                  1'b1, 64'h1122_3344_5566_7788, 1'b0};
    vecs[2]  = '{1'b1, 64'h8000_0008, MSIZE8, 8'h0F, 64'h0000_0000_AABB_CCDD, 1'b0, 64'h0,                  1'b0};
    vecs[3]  = '{1'b1, 64'h8000_0008, MSIZE8, 8'h00, 64'h0,                  1'b1, 64'h1122_3344_AABB_CCDD, 1'b0};
    vecs[4]  = '{1'b0, 64'h8000_000C, MSIZE4, 8'h00, 64'h0,                  1'b1, 64'h0000_0000_1122_3344, 1'b0};
    vecs[5]  = '{1'b0, 64'h8000_0008, MSIZE4, 8'h00, 64'h0,                  1'b1, 64'h0000_0000_AABB_CCDD, 1'b0};
    vecs[6]  = '{1'b1, 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0,                  1'b1, 64'h0,                  1'b1};
    vecs[7]  = '{1'b1, 64'h7FFF_FFF8, MSIZE8, 8'hFF, 64'h1,                  1'b0, 64'h0,                  1'b1};
    vecs[8]  = '{1'b1, 64'h8000_8000, MSIZE8, 8'h00, 64'h0,                  1'b1, 64'h0,                  1'b1};
    vecs[9]  = '{1'b1, 64'h8000_7FF8, MSIZE8, 8'hFF, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 64'h0,                  1'b0};
    vecs[10] = '{1'b1, 64'h8000_7FF8, MSIZE8, 8'h00, 64'h0,                  1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0};
    vecs[11] = '{1'b1, 64'h8000_000C, MSIZE8, 8'hF0, 64'hFFFF_FFFF_0000_0000, 1'b0, 64'h0,                  1'b1};
    vecs[12] = '{1'b1, 64'h8000_000C, MSIZE8, 8'h00, 64'h0,                  1'b1, 64'h1122_3344_AABB_CCDD, 1'b1};
    vecs[13] = '{1'b1, 64'h8000_000C, MSIZE4, 8'hF0, 64'h9988_7766_0000_0000, 1'b0, 64'h0,                  1'b0};
    vecs[14] = '{1'b1, 64'h8000_0008, MSIZE8, 8'h00, 64'h0,                  1'b1, 64'h9988_7766_AABB_CCDD, 1'b0};
    vecs[15] = '{1'b1, 64'h8000_0008, MSIZE8, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h9988_7766_AABB_CCDD, 1'b0};
    vecs[16] = '{1'b1, 64'h8000_0008, MSIZE8, 8'h00, 64'h0,                  1'b1, 64'h9988_7766_AABB_CCDD, 1'b0};
    vecs[17] = '{1'b0, 64'h7FFF_FFFC, MSIZE4, 8'h00, 64'h0,                  1'b1, 64'h0,                  1'b1};
    vecs[18] = '{1'b1, 64'h8000_0009, MSIZE1, 8'h02, 64'h0000_0000_0000_EE00, 1'b0, 64'h0,                  1'b0};
    vecs[19] = '{1'b1, 64'h8000_0008, MSIZE8, 8'h00, 64'h0,                  1'b1, W1_FIN,                 1'b0};

    rb = '{1'b1, W1_ADDR, MSIZE8, 8'h00, 64'h0, 1'b1, W1_FIN, 1'b0};

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    chk("reset dresp", {62'b0, dresp.addr_ok, dresp.data_ok} | dresp.data, 64'h0);
    chk("reset iresp", {30'b0, iresp.addr_ok, iresp.data_ok, iresp.data}, 64'h0);
    chk("reset err", {62'b0, err, err0}, 64'h0);
    chk("reset dut0 ok", {60'b0, dresp0.addr_ok, dresp0.data_ok, iresp0.addr_ok, iresp0.data_ok}, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Both ports valid together: D first, I LATENCY+2 cycles later.
    sb.push_back('{1'b1, 1'b1, W1_FIN, 1'b0, int'(LAT_A) + 1});
    sb.push_back('{1'b0, 1'b1, 64'h0000_0000_9988_7766, 1'b0, 2 * int'(LAT_A) + 3});
    dreq = '{1'b1, W1_ADDR, MSIZE8, 8'h00, 64'h0};
    ireq = '{1'b1, 64'h8000_000C};
    dd = 1'b0;
    id = 1'b0;
    for (int c = 1; c <= 20 && !(dd && id); c++) begin
      @(negedge clk);
      if (dresp.data_ok || iresp.data_ok) begin
        pop_check("both", c);
        if (dresp.data_ok) begin dd = 1'b1; dreq.valid = 1'b0; end
        if (iresp.data_ok) begin id = 1'b1; ireq.valid = 1'b0; end
      end
    end
    dreq.valid = 1'b0;
    ireq.valid = 1'b0;
    chk("both completed", {62'b0, dd, id}, 64'h3);
    sb.delete();
    @(negedge clk);

    // Store flushed during WAIT: no response, no write.
    dreq = '{1'b1, W1_ADDR, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
    @(negedge clk);
    chk("flush wait ok", {62'b0, dresp.addr_ok, dresp.data_ok}, 64'h0);
    dreq.valid = 1'b0;
    @(negedge clk);
    chk("flush state", 64'(dut.state_q), 64'(IDLE));
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dresp.data_ok || dresp.addr_ok) seen = 1'b1;
    end
    chk("flush no resp", 64'(seen), 64'h0);
    run_txn("flush readback", rb);

    // Reset pulled during WAIT of a store.
    dreq = '{1'b1, W1_ADDR, MSIZE8, 8'hFF, 64'h7777_7777_7777_7777};
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst wait outs", {61'b0, err, dresp.data_ok, iresp.data_ok}, 64'h0);
    chk("rst wait state", 64'(dut.state_q), 64'(IDLE));
    @(negedge clk);
    dreq.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    run_txn("rst wait readback", rb);

    // Reset pulled while the store's RESP is on the bus.
    dreq = '{1'b1, W1_ADDR, MSIZE8, 8'hFF, 64'h6666_6666_6666_6666};
    repeat (LAT_A + 1) @(negedge clk);
    chk("rst resp ok seen", 64'(dresp.data_ok), 64'h1);
    rst = 1'b0;
    #1;
    chk("rst resp outs", {61'b0, err, dresp.data_ok, dresp.addr_ok}, 64'h0);
    chk("rst resp data", dresp.data, 64'h0);
    @(negedge clk);
    dreq.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    run_txn("rst resp readback", rb);

    // LATENCY=0 instance: data_ok one cycle after valid.
    dreq0 = '{1'b1, 64'h8000_0040, MSIZE8, 8'hFF, 64'hC0FF_EE00_1234_5678};
    @(negedge clk);
    chk("lat0 store ok", {62'b0, dresp0.addr_ok, dresp0.data_ok}, 64'h3);
    chk("lat0 store err", 64'(err0), 64'h0);
    dreq0.valid = 1'b0;
    @(negedge clk);
    chk("lat0 idle", 64'(dresp0.data_ok), 64'h0);
    dreq0 = '{1'b1, 64'h8000_0040, MSIZE8, 8'h00, 64'h0};
    @(negedge clk);
    chk("lat0 load ok", 64'(dresp0.data_ok), 64'h1);
    chk("lat0 load data", dresp0.data, 64'hC0FF_EE00_1234_5678);
    dreq0.valid = 1'b0;
    @(negedge clk);
    ireq0 = '{1'b1, 64'h8000_0044};
    @(negedge clk);
    chk("lat0 fetch ok", {62'b0, iresp0.addr_ok, iresp0.data_ok}, 64'h3);
    chk("lat0 fetch data", {32'b0, iresp0.data}, 64'h0000_0000_C0FF_EE00);
    ireq0.valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
